// File: rtl/pipeline_controller_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pkg_defines                                                          |
// | Shared types and constants for the pipeline control block.           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pkg_defines;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2,
    ERROR = 2'd3
  } ctrl_state_t;

  localparam int unsigned c_flush_cycles_default = 2;
  // Wide enough for FLUSH_CYCLES-1 over the whole legal range 1..15.
  localparam int unsigned c_flush_cnt_width      = 4;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sat_counter                                                          |
// | Up-counter that sticks at its all-ones value instead of wrapping.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_value
);

  logic [WIDTH-1:0] r_value;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_value <= '0;
    end else if (i_inc && (r_value != {WIDTH{1'b1}})) begin
      r_value <= r_value + 1'b1;
    end
  end

  assign o_value = r_value;

endmodule
`default_nettype wire

// File: rtl/pipeline_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipeline_controller                                                  |
// | Halt/flush/error sequencing for the instruction-processor front end. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pipeline_controller
  import pkg_defines::*;
#(
  parameter int unsigned FLUSH_CYCLES = c_flush_cycles_default,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_jmp_write,
  input  logic [1:0]           i_cache_hit,
  input  logic                 i_no_ren,
  input  logic                 i_full,
  input  logic                 i_panic,
  output logic                 o_ld_halt,
  output logic [1:0]           o_dec_halt,
  output logic                 o_ren_halt,
  output logic                 o_flush,
  output logic                 o_error,
  output logic [CNT_WIDTH-1:0] o_stall_cycles
);

  localparam logic [c_flush_cnt_width-1:0] c_flush_load =
    c_flush_cnt_width'(FLUSH_CYCLES - 1);

  ctrl_state_t                  r_state;
  ctrl_state_t                  w_next_state;
  logic [c_flush_cnt_width-1:0] r_flush_cnt;
  logic [c_flush_cnt_width-1:0] w_next_cnt;
  logic                         r_halt;
  logic                         r_flush;
  logic                         r_error;
  logic                         w_stall_req;
  logic                         w_run;

  assign w_stall_req = i_no_ren | i_full;

  // A stall request never cuts a flush window short; it is only honoured
  // once the counter has run out.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_flush_cnt;
    if (r_state != ERROR) begin
      if (i_panic) begin
        w_next_state = ERROR;
        w_next_cnt   = '0;
      end else if (i_jmp_write) begin
        w_next_state = FLUSH;
        w_next_cnt   = c_flush_load;
      end else if ((r_state == FLUSH) && (r_flush_cnt != '0)) begin
        w_next_cnt   = r_flush_cnt - 1'b1;
      end else begin
        w_next_state = w_stall_req ? STALL : RUN;
      end
    end
  end

  // Outputs are registered from the next state so they always match r_state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= RUN;
      r_flush_cnt <= '0;
      r_halt      <= 1'b0;
      r_flush     <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_flush_cnt <= w_next_cnt;
      r_halt      <= (w_next_state != RUN);
      r_flush     <= (w_next_state == FLUSH);
      r_error     <= (w_next_state == ERROR);
    end
  end

  assign w_run      = (r_state == RUN);
  assign o_ld_halt  = r_halt;
  assign o_ren_halt = r_halt;
  assign o_flush    = r_flush;
  assign o_error    = r_error;
  assign o_dec_halt = {2{r_halt}} | ({2{w_run}} & ~i_cache_hit);

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_stall_counter (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (r_state == STALL),
    .o_value (o_stall_cycles)
  );

endmodule
`default_nettype wire
